// File: rtl/benes_cfg_loader.sv
// Configuration loader for the 16x16 Benes network. It collects one switch word per stage into a shadow bank and then commits all stages to the network in a single clock edge.
// Optional feature: define BENES_CFG_PARITY_EN to add the cfg_par input, which carries an even-parity check bit for each beat.
module benes_cfg_loader #(
    parameter int N_STAGES     = 7,
    parameter int SW_PER_STAGE = 8,
    parameter int IDX_W        = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [SW_PER_STAGE-1:0] cfg_data,
    input  logic                    cfg_last,
`ifdef BENES_CFG_PARITY_EN
    input  logic                    cfg_par,
`endif
    input  logic                    commit_hold,
    output logic [SW_PER_STAGE-1:0] switch_set [0:N_STAGES-1],
    output logic                    cfg_done,
    output logic                    cfg_err,
    output logic                    cfg_loaded
);

    typedef enum logic [1:0] {LOAD, DROP, COMMIT_WAIT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        wr_idx_reg, wr_idx_next;
    logic [SW_PER_STAGE-1:0] shadow_reg [0:N_STAGES-1];
    logic [N_STAGES-1:0]     stage_we;
    logic                    beat, shadow_wr, commit, err_next, par_ok;

    assign cfg_ready = (state_reg != COMMIT_WAIT);
    assign beat      = cfg_valid && cfg_ready;

`ifdef BENES_CFG_PARITY_EN
    assign par_ok = ~^{cfg_data, cfg_par};
`else
    assign par_ok = 1'b1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_STAGES; gi++) begin : g_we
            assign stage_we[gi] = shadow_wr && (wr_idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        wr_idx_next = wr_idx_reg;
        shadow_wr   = 1'b0;
        commit      = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            LOAD: begin
                if (beat) begin
                    shadow_wr = 1'b1;
                    if (!par_ok) begin
                        // A bad-parity beat poisons the frame, so drop the rest of it.
                        err_next    = 1'b1;
                        wr_idx_next = '0;
                        state_next  = cfg_last ? LOAD : DROP;
                    end else if (cfg_last) begin
                        wr_idx_next = '0;
                        if (wr_idx_reg == LAST_IDX) state_next = COMMIT_WAIT;
                        else                        err_next   = 1'b1;
                    end else if (wr_idx_reg == LAST_IDX) begin
                        err_next    = 1'b1;
                        wr_idx_next = '0;
                        state_next  = DROP;
                    end else begin
                        wr_idx_next = wr_idx_reg + IDX_W'(1);
                    end
                end
            end
            DROP: begin
                if (beat && cfg_last) begin
                    state_next  = LOAD;
                    wr_idx_next = '0;
                end
            end
            COMMIT_WAIT: begin
                if (!commit_hold) begin
                    commit     = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= LOAD;
            wr_idx_reg <= '0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_loaded <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_idx_reg <= wr_idx_next;
            cfg_done   <= commit;
            cfg_err    <= err_next;
            cfg_loaded <= cfg_loaded | commit;
        end
    end

    // Every stage copies from the shadow bank on the same edge, so the network never sees a mixed configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STAGES; i++) begin
                shadow_reg[i] <= '0;
                switch_set[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (stage_we[i]) shadow_reg[i] <= cfg_data;
                if (commit)      switch_set[i] <= shadow_reg[i];
            end
        end
    end

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Scoreboard bench for benes_cfg_loader. The stimulus thread queues each expected cfg_done or cfg_err event, and a monitor thread checks the events as the DUT produces them.
module tb_benes_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_last = 1'b0;
    logic       commit_hold = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready, cfg_done, cfg_err, cfg_loaded;
    logic [7:0] switch_set [0:6];
`ifdef BENES_CFG_PARITY_EN
    logic       cfg_par = 1'b0;
    bit         bad_par_next = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    typedef struct {
        bit          is_err;
        logic [55:0] sw;
        logic        loaded;
    } exp_t;
    exp_t exp_q[$];

    benes_cfg_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .cfg_last    (cfg_last),
`ifdef BENES_CFG_PARITY_EN
        .cfg_par     (cfg_par),
`endif
        .commit_hold (commit_hold),
        .switch_set  (switch_set),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .cfg_loaded  (cfg_loaded)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] pack_sw();
        logic [55:0] v;
        for (int k = 0; k < 7; k++) v[8*k +: 8] = switch_set[k];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input bit is_err, input logic [55:0] sw);
        exp_t e;
        e.is_err = is_err;
        e.sw     = sw;
        e.loaded = 1'b1;
        exp_q.push_back(e);
    endtask

    // The task is called about 1 ns after a rising edge and returns about 1 ns after the edge that accepts the beat.
    task automatic send_beat(input logic [7:0] d, input logic l);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
`ifdef BENES_CFG_PARITY_EN
        cfg_par      = (^d) ^ bad_par_next;
        bad_par_next = 1'b0;
`endif
        while (!cfg_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cfg_ready) chk("ready_timeout", 64'(cfg_ready), 64'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [55:0] v);
        for (int k = 0; k < 7; k++) send_beat(v[8*k +: 8], k == 6);
    endtask

    // The monitor prints one line for each DUT event and compares it with the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (cfg_done || cfg_err)) begin
                txn++;
                $display("txn %0d: done=%0b err=%0b loaded=%0b sw=%h", txn, cfg_done, cfg_err, cfg_loaded, pack_sw());
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {62'd0, cfg_done, cfg_err}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_err",    64'(cfg_err),    64'(e.is_err));
                    chk("evt_done",   64'(cfg_done),   64'(!e.is_err));
                    chk("evt_sw",     64'(pack_sw()),  64'(e.sw));
                    chk("evt_loaded", 64'(cfg_loaded), 64'(e.loaded));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] v1, vf, v55, v4, vc3, v5;
        v1  = 56'h40201008040201;
        vf  = {7{8'hFF}};
        v55 = {7{8'h55}};
        v4  = 56'h16151413121110;
        vc3 = {7{8'hC3}};
        v5  = 56'hA6A5A4A3A2A1A0;

        // Check the reset state.
        #12;
        chk("rst_sw",     64'(pack_sw()), 64'd0);
        chk("rst_ready",  64'(cfg_ready), 64'd1);
        chk("rst_done",   64'(cfg_done),  64'd0);
        chk("rst_err",    64'(cfg_err),   64'd0);
        chk("rst_loaded", 64'(cfg_loaded),64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: load a walking-ones frame and commit it.
        push_exp(1'b0, v1);
        send_frame(v1);
        chk("t1_wait_sw", 64'(pack_sw()), 64'd0);
        @(posedge clk); #1;
        chk("t1_sw",   64'(pack_sw()), 64'(v1));
        chk("t1_done", 64'(cfg_done),  64'd1);
        @(posedge clk); #1;
        chk("t1_done_pulse", 64'(cfg_done), 64'd0);

        // Test 2: hold the commit with commit_hold, then release it.
        commit_hold = 1'b1;
        push_exp(1'b0, vf);
        send_frame(vf);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("t2_hold_ready", 64'(cfg_ready), 64'd0);
            chk("t2_hold_sw",    64'(pack_sw()), 64'(v1));
        end
        commit_hold = 1'b0;
        @(posedge clk); #1;
        chk("t2_sw",   64'(pack_sw()), 64'(vf));
        chk("t2_done", 64'(cfg_done),  64'd1);
        @(posedge clk); #1;

        // Test 3: a short frame raises an error, then a full frame commits.
        push_exp(1'b1, vf);
        for (int k = 0; k < 4; k++) send_beat(8'hAA, k == 3);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_short_sw", 64'(pack_sw()), 64'(vf));
        push_exp(1'b0, v55);
        send_frame(v55);
        @(posedge clk); #1;
        chk("t3_sw", 64'(pack_sw()), 64'(v55));
        @(posedge clk); #1;

        // Test 4: a long frame errors once at beat 7; the remaining beats are dropped.
        push_exp(1'b1, v55);
        for (int k = 0; k < 9; k++) send_beat(8'h33, k == 8);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_long_sw", 64'(pack_sw()), 64'(v55));
        push_exp(1'b0, v4);
        send_frame(v4);
        @(posedge clk); #1;
        chk("t4_sw", 64'(pack_sw()), 64'(v4));
        @(posedge clk); #1;

        // Test 5: assert reset in the middle of a frame.
        push_exp(1'b0, vc3);
        send_frame(vc3);
        @(posedge clk); #1;
        chk("t5_c3_sw", 64'(pack_sw()), 64'(vc3));
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) send_beat(8'h99, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sw",     64'(pack_sw()),  64'd0);
        chk("t5_rst_loaded", 64'(cfg_loaded), 64'd0);
        chk("t5_rst_ready",  64'(cfg_ready),  64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_exp(1'b0, v5);
        send_frame(v5);
        @(posedge clk); #1;
        chk("t5_sw", 64'(pack_sw()), 64'(v5));
        @(posedge clk); #1;

`ifdef BENES_CFG_PARITY_EN
        // Test 6: a parity error on beat 2 drops the frame, then a frame with good parity commits.
        push_exp(1'b1, v5);
        send_beat(8'h03, 1'b0);
        bad_par_next = 1'b1;
        send_beat(8'h07, 1'b0);
        for (int k = 2; k < 7; k++) send_beat(8'h11, k == 6);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_par_sw", 64'(pack_sw()), 64'(v5));
        push_exp(1'b0, v4);
        send_frame(v4);
        @(posedge clk); #1;
        chk("t6_sw", 64'(pack_sw()), 64'(v4));
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
